// File: rtl/avalon_mm_ram_agent_if.sv
// Avalon-MM host/agent bus bundle.
// Host side drives commands, agent side returns data.
interface avalon_mm_ram_agent_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] host_to_agent;
  logic        waitrequest;
  logic [31:0] agent_to_host;
  logic        readdatavalid;
  logic        protocol_error;

  modport master (
    output address, byteenable, read, write,
    output host_to_agent,
    input  waitrequest, agent_to_host,
    input  readdatavalid, protocol_error
  );

  modport slave (
    input  address, byteenable, read, write,
    input  host_to_agent,
    output waitrequest, agent_to_host,
    output readdatavalid, protocol_error
  );
endinterface

// File: rtl/avalon_mm_ram_agent.sv
// Avalon-MM RAM agent: wait states, pipelined
// reads with bounded outstanding, sticky errors.
module avalon_mm_ram_agent #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_STATES  = 1,
  parameter int MAX_PENDING  = 2
) (
  input  logic clk,
  input  logic rst,
  avalon_mm_ram_agent_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int RL = READ_LATENCY;
  localparam logic [2:0] WS3 = 3'(WAIT_STATES);
  localparam logic [3:0] MAXP = 4'(MAX_PENDING);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic        hold_rd_q, hold_rd_d;
  logic        hold_wr_q, hold_wr_d;
  logic [3:0]  pend_q, pend_d;
  logic        perr_q, perr_d;
  logic [RL-1:0] vld_q, vld_d;
  logic [31:0] dat_q [RL];
  logic [31:0] dat_d [RL];

  logic [31:0] ram_mem [DEPTH_WORDS];

  logic          cmd;
  logic          both;
  logic          rd_full;
  logic          changed;
  logic          wreq;
  logic          abort;
  logic          accept;
  logic          wr_acc;
  logic          rd_acc;
  logic          rsp_ret;
  logic [AW-1:0] idx;

  assign idx  = bus.address[AW+1:2];
  assign cmd  = bus.read | bus.write;
  assign both = bus.read & bus.write;

  // A pure read is held off while the
  // response window is full; writes pass.
  assign rd_full = bus.read & ~bus.write &
                   (pend_q == MAXP);

  assign changed =
    (bus.address != hold_addr_q) |
    (bus.read    != hold_rd_q)   |
    (bus.write   != hold_wr_q);

  // Wait-state FSM next state and stall.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hold_addr_d = hold_addr_q;
    hold_rd_d   = hold_rd_q;
    hold_wr_d   = hold_wr_q;
    wreq        = 1'b0;
    abort       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd) begin
          if (WAIT_STATES == 0) begin
            wreq = rd_full;
          end else begin
            wreq        = 1'b1;
            state_d     = HOLD;
            wait_cnt_d  = 3'd1;
            hold_addr_d = bus.address;
            hold_rd_d   = bus.read;
            hold_wr_d   = bus.write;
          end
        end
      end
      HOLD: begin
        if (!cmd || changed) begin
          abort      = 1'b1;
          wreq       = cmd;
          state_d    = IDLE;
          wait_cnt_d = 3'd0;
        end else if (wait_cnt_q < WS3) begin
          wreq       = 1'b1;
          wait_cnt_d = wait_cnt_q + 3'd1;
        end else begin
          wreq = rd_full;
          if (!rd_full) begin
            state_d    = IDLE;
            wait_cnt_d = 3'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Acceptance is gated by reset so a held
  // command cannot touch RAM while in reset.
  assign accept  = rst & cmd & ~wreq;
  assign wr_acc  = accept & bus.write;
  assign rd_acc  = accept & bus.read & ~bus.write;
  assign rsp_ret = vld_q[RL-1];

  // Outstanding count, error flag, pipeline.
  always_comb begin
    pend_d = pend_q;
    case ({rd_acc, rsp_ret})
      2'b10:   pend_d = pend_q + 4'd1;
      2'b01:   pend_d = pend_q - 4'd1;
      default: pend_d = pend_q;
    endcase
    perr_d = perr_q | both | abort;
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? ram_mem[idx] : '0;
    for (int i = 1; i < RL; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Control and response state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 3'd0;
      hold_addr_q <= '0;
      hold_rd_q   <= 1'b0;
      hold_wr_q   <= 1'b0;
      pend_q      <= 4'd0;
      perr_q      <= 1'b0;
      vld_q       <= '0;
      for (int i = 0; i < RL; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hold_addr_q <= hold_addr_d;
      hold_rd_q   <= hold_rd_d;
      hold_wr_q   <= hold_wr_d;
      pend_q      <= pend_d;
      perr_q      <= perr_d;
      vld_q       <= vld_d;
      for (int i = 0; i < RL; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) begin
          ram_mem[idx][8*b +: 8] <=
            bus.host_to_agent[8*b +: 8];
        end
      end
    end
  end

  assign bus.waitrequest    = rst & wreq;
  assign bus.readdatavalid  = vld_q[RL-1];
  assign bus.agent_to_host  =
    vld_q[RL-1] ? dat_q[RL-1] : '0;
  assign bus.protocol_error = perr_q;

endmodule

// File: tb/tb_avalon_mm_ram_agent.sv
// Directed bench for avalon_mm_ram_agent:
// default instance A, zero-wait instance B.
module tb_avalon_mm_ram_agent;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   a2h_bad = 0;

  logic [31:0] qa_d[$];
  int          qa_e[$];
  logic [31:0] qb_d[$];
  int          qb_e[$];

  avalon_mm_ram_agent_if ifa ();
  avalon_mm_ram_agent_if ifb ();

  avalon_mm_ram_agent dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  avalon_mm_ram_agent #(
    .DEPTH_WORDS  (1024),
    .READ_LATENCY (4),
    .WAIT_STATES  (0),
    .MAX_PENDING  (2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response capture with sample edge index.
  always @(negedge clk) begin
    if (ifa.readdatavalid) begin
      qa_d.push_back(ifa.agent_to_host);
      qa_e.push_back(cyc + 1);
    end else if (ifa.agent_to_host !== 32'h0) begin
      a2h_bad++;
    end
    if (ifb.readdatavalid) begin
      qb_d.push_back(ifb.agent_to_host);
      qb_e.push_back(cyc + 1);
    end else if (ifb.agent_to_host !== 32'h0) begin
      a2h_bad++;
    end
  end

  function automatic logic wreq(input bit sel);
    return sel ? ifb.waitrequest : ifa.waitrequest;
  endfunction

  function automatic int qsize(input bit sel);
    return sel ? qb_d.size() : qa_d.size();
  endfunction

  task automatic drive(
    input bit sel, input logic rd, input logic wr,
    input logic [31:0] a, input logic [3:0] be,
    input logic [31:0] d);
    if (sel) begin
      ifb.read = rd; ifb.write = wr;
      ifb.address = a; ifb.byteenable = be;
      ifb.host_to_agent = d;
    end else begin
      ifa.read = rd; ifa.write = wr;
      ifa.address = a; ifa.byteenable = be;
      ifa.host_to_agent = d;
    end
  endtask

  task automatic idle(input bit sel);
    drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Present a command until accepted (bounded).
  task automatic issue(
    input bit sel, input logic rd, input logic wr,
    input logic [31:0] a, input logic [3:0] be,
    input logic [31:0] d,
    output int waits, output int acc);
    drive(sel, rd, wr, a, be, d);
    #1;
    waits = 0;
    while (wreq(sel) && waits < 50) begin
      @(negedge clk); #1;
      waits++;
    end
    acc = cyc + 1;
    @(negedge clk);
    idle(sel);
  endtask

  task automatic wait_q(input bit sel, input int n);
    for (int i = 0; i < 40 && qsize(sel) < n; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(1'b0); idle(1'b1);
    ifa.read = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ifa.waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL rst_wreq got=%b exp=0",
               ifa.waitrequest);
    end
    total++;
    if (ifa.readdatavalid !== 1'b0 ||
        ifb.readdatavalid !== 1'b0) begin
      bad++;
      $display("FAIL rst_rdv got=%b%b exp=00",
               ifa.readdatavalid, ifb.readdatavalid);
    end
    total++;
    if (ifa.protocol_error !== 1'b0 ||
        ifa.agent_to_host !== 32'h0) begin
      bad++;
      $display("FAIL rst_out got=%b/%h exp=0/0",
               ifa.protocol_error, ifa.agent_to_host);
    end
    idle(1'b0);
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if (ifa.waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL idle_wreq got=%b exp=0",
               ifa.waitrequest);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w, k, k2;
    logic [31:0] d;
    issue(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, w, k);
    total++;
    if (w !== 1) begin
      bad++;
      $display("FAIL basic_wr_wait got=%0d exp=1", w);
    end
    issue(0, 1, 0, 32'h10, 4'hF, 32'h0, w, k);
    total++;
    if (w !== 1) begin
      bad++;
      $display("FAIL basic_rd_wait got=%0d exp=1", w);
    end
    wait_q(0, 1);
    total++;
    if (qa_d.size() !== 1) begin
      bad++;
      $display("FAIL basic_cnt got=%0d exp=1",
               qa_d.size());
    end else begin
      d = qa_d.pop_front();
      k2 = qa_e.pop_front();
      total++;
      if (d !== 32'hDEADBEEF || k2 !== k + 2) begin
        bad++;
        $display("FAIL basic_rsp got=%h@%0d exp=%h@%0d",
                 d, k2, 32'hDEADBEEF, k + 2);
      end
    end
  endtask

  task automatic test_lanes();
    int w, k;
    logic [31:0] d;
    issue(0, 0, 1, 32'h20, 4'hF, 32'h11223344, w, k);
    issue(0, 0, 1, 32'h20, 4'h5, 32'hAABBCCDD, w, k);
    issue(0, 0, 1, 32'h20, 4'h0, 32'hFFFFFFFF, w, k);
    total++;
    if (w !== 1) begin
      bad++;
      $display("FAIL be0_wait got=%0d exp=1", w);
    end
    issue(0, 1, 0, 32'h20, 4'hF, 32'h0, w, k);
    wait_q(0, 1);
    total++;
    if (qa_d.size() !== 1) begin
      bad++;
      $display("FAIL lanes_cnt got=%0d exp=1",
               qa_d.size());
    end else begin
      d = qa_d.pop_front();
      void'(qa_e.pop_front());
      total++;
      if (d !== 32'h11BB33DD) begin
        bad++;
        $display("FAIL lanes got=%h exp=11bb33dd", d);
      end
    end
  endtask

  task automatic test_alias();
    int w, k;
    logic [31:0] d;
    issue(0, 0, 1, 32'h1004, 4'hF, 32'h5A5A5A5A, w, k);
    issue(0, 1, 0, 32'h0004, 4'hF, 32'h0, w, k);
    issue(0, 1, 0, 32'h0006, 4'hF, 32'h0, w, k);
    wait_q(0, 2);
    total++;
    if (qa_d.size() !== 2) begin
      bad++;
      $display("FAIL alias_cnt got=%0d exp=2",
               qa_d.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        d = qa_d.pop_front();
        void'(qa_e.pop_front());
        total++;
        if (d !== 32'h5A5A5A5A) begin
          bad++;
          $display("FAIL alias%0d got=%h exp=5a5a5a5a",
                   i, d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int w, k, c, st;
    logic [31:0] d;
    int e;
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 1, 32'(4 * i), 4'hF,
            32'hB0B00000 + 32'(4 * i), w, k);
      total++;
      if (w !== 0) begin
        bad++;
        $display("FAIL b_wr_wait%0d got=%0d exp=0",
                 i, w);
      end
    end
    c = cyc;
    drive(1, 1, 0, 32'h0, 4'hF, 32'h0);
    #1;
    total++;
    if (ifb.waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL b2b_r0 got=%b exp=0",
               ifb.waitrequest);
    end
    @(negedge clk);
    drive(1, 1, 0, 32'h4, 4'hF, 32'h0);
    #1;
    total++;
    if (ifb.waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL b2b_r1 got=%b exp=0",
               ifb.waitrequest);
    end
    @(negedge clk);
    drive(1, 1, 0, 32'h8, 4'hF, 32'h0);
    #1;
    st = 0;
    while (ifb.waitrequest && st < 50) begin
      @(negedge clk); #1;
      st++;
    end
    total++;
    if (st !== 3) begin
      bad++;
      $display("FAIL b2b_stall got=%0d exp=3", st);
    end
    @(negedge clk);
    idle(1);
    wait_q(1, 3);
    total++;
    if (qb_d.size() !== 3) begin
      bad++;
      $display("FAIL b2b_cnt got=%0d exp=3",
               qb_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        d = qb_d.pop_front();
        e = qb_e.pop_front();
        total++;
        if (d !== 32'hB0B00000 + 32'(4 * i) ||
            e !== c + ((i == 2) ? 10 : 5 + i)) begin
          bad++;
          $display("FAIL b2b_rsp%0d got=%h@%0d", i,
                   d, e - c);
        end
      end
    end
  endtask

  task automatic test_write_unblocked();
    int w, k;
    logic [31:0] d;
    drive(1, 1, 0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    drive(1, 1, 0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    drive(1, 0, 1, 32'hC, 4'hF, 32'h0000CAFE);
    #1;
    total++;
    if (ifb.waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL wr_unblk got=%b exp=0",
               ifb.waitrequest);
    end
    @(negedge clk);
    idle(1);
    wait_q(1, 2);
    qb_d.delete(); qb_e.delete();
    drive(1, 0, 1, 32'h10, 4'hF, 32'h12345678);
    @(negedge clk);
    drive(1, 1, 0, 32'h10, 4'hF, 32'h0);
    @(negedge clk);
    idle(1);
    issue(1, 1, 0, 32'hC, 4'hF, 32'h0, w, k);
    wait_q(1, 2);
    total++;
    if (qb_d.size() !== 2) begin
      bad++;
      $display("FAIL raw_cnt got=%0d exp=2",
               qb_d.size());
    end else begin
      d = qb_d.pop_front();
      total++;
      if (d !== 32'h12345678) begin
        bad++;
        $display("FAIL raw got=%h exp=12345678", d);
      end
      d = qb_d.pop_front();
      total++;
      if (d !== 32'h0000CAFE) begin
        bad++;
        $display("FAIL wr_data got=%h exp=0000cafe", d);
      end
      qb_e.delete();
    end
  endtask

  task automatic test_rw_conflict();
    int w, k;
    logic [31:0] d;
    total++;
    if (ifa.protocol_error !== 1'b0) begin
      bad++;
      $display("FAIL perr_pre got=%b exp=0",
               ifa.protocol_error);
    end
    issue(0, 1, 1, 32'h30, 4'hF, 32'h0000FFFF, w, k);
    repeat (8) @(negedge clk);
    total++;
    if (qa_d.size() !== 0) begin
      bad++;
      $display("FAIL rw_rdv got=%0d exp=0",
               qa_d.size());
    end
    total++;
    if (ifa.protocol_error !== 1'b1) begin
      bad++;
      $display("FAIL rw_perr got=%b exp=1",
               ifa.protocol_error);
    end
    issue(0, 1, 0, 32'h30, 4'hF, 32'h0, w, k);
    wait_q(0, 1);
    total++;
    if (qa_d.size() !== 1) begin
      bad++;
      $display("FAIL rw_cnt got=%0d exp=1",
               qa_d.size());
    end else begin
      d = qa_d.pop_front();
      void'(qa_e.pop_front());
      total++;
      if (d !== 32'h0000FFFF) begin
        bad++;
        $display("FAIL rw_data got=%h exp=0000ffff", d);
      end
    end
    total++;
    if (ifa.protocol_error !== 1'b1) begin
      bad++;
      $display("FAIL perr_sticky got=%b exp=1",
               ifa.protocol_error);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d;
    drive(1, 1, 0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    drive(1, 1, 0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    idle(1);
    rst = 1'b0;
    #1;
    total++;
    if (ifb.readdatavalid !== 1'b0) begin
      bad++;
      $display("FAIL ri_rdv got=%b exp=0",
               ifb.readdatavalid);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (qb_d.size() !== 0) begin
      bad++;
      $display("FAIL ri_stale got=%0d exp=0",
               qb_d.size());
    end
    total++;
    if (ifa.protocol_error !== 1'b0) begin
      bad++;
      $display("FAIL ri_perr got=%b exp=0",
               ifa.protocol_error);
    end
    drive(1, 1, 0, 32'h8, 4'hF, 32'h0);
    #1;
    total++;
    if (ifb.waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL ri_r0 got=%b exp=0",
               ifb.waitrequest);
    end
    @(negedge clk);
    drive(1, 1, 0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    drive(1, 1, 0, 32'h0, 4'hF, 32'h0);
    #1;
    total++;
    if (ifb.waitrequest !== 1'b1) begin
      bad++;
      $display("FAIL ri_full got=%b exp=1",
               ifb.waitrequest);
    end
    idle(1);
    wait_q(1, 2);
    total++;
    if (qb_d.size() !== 2) begin
      bad++;
      $display("FAIL ri_cnt got=%0d exp=2",
               qb_d.size());
    end else begin
      d = qb_d.pop_front();
      total++;
      if (d !== 32'hB0B00008) begin
        bad++;
        $display("FAIL ri_data got=%h exp=b0b00008", d);
      end
      qb_d.delete(); qb_e.delete();
    end
  endtask

  task automatic test_hold_abort();
    int w, k;
    logic [31:0] d;
    drive(0, 1, 0, 32'h40, 4'hF, 32'h0);
    #1;
    total++;
    if (ifa.waitrequest !== 1'b1) begin
      bad++;
      $display("FAIL ab_wreq got=%b exp=1",
               ifa.waitrequest);
    end
    @(negedge clk);
    idle(0);
    @(negedge clk);
    total++;
    if (ifa.protocol_error !== 1'b1) begin
      bad++;
      $display("FAIL ab_perr got=%b exp=1",
               ifa.protocol_error);
    end
    repeat (5) @(negedge clk);
    total++;
    if (qa_d.size() !== 0) begin
      bad++;
      $display("FAIL ab_rdv got=%0d exp=0",
               qa_d.size());
    end
    issue(0, 1, 0, 32'h10, 4'hF, 32'h0, w, k);
    wait_q(0, 1);
    total++;
    if (qa_d.size() !== 1) begin
      bad++;
      $display("FAIL keep_cnt got=%0d exp=1",
               qa_d.size());
    end else begin
      d = qa_d.pop_front();
      void'(qa_e.pop_front());
      total++;
      if (d !== 32'hDEADBEEF) begin
        bad++;
        $display("FAIL ram_kept got=%h exp=deadbeef",
                 d);
      end
    end
    total++;
    if (a2h_bad !== 0) begin
      bad++;
      $display("FAIL a2h_zero got=%0d exp=0", a2h_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_alias();
    test_back_to_back();
    test_write_unblocked();
    test_rw_conflict();
    test_reset_inflight();
    test_hold_abort();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/avalon_mm_ram_agent.md
AVALON_MM_RAM_AGENT -- requirements
Module: avalon_mm_ram_agent

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit RAM words (power of two, >= 2).
REQ-002 SHALL have parameter READ_LATENCY, default 2, meaning cycles from read acceptance to readdatavalid (1..8).
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning waitrequest cycles inserted per command before acceptance (0..7).
REQ-004 SHALL have parameter MAX_PENDING, default 2, meaning maximum reads accepted but not yet returned (1..8).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous assert, active-low (0 = in reset), synchronous release.
REQ-007 SHALL have port address  input  32  byte address from host.
REQ-008 SHALL have port byteenable  input  4  lane enables; bit i selects bits 8i+7:8i.
REQ-009 SHALL have port read  input  1  read command.
REQ-010 SHALL have port write  input  1  write command.
REQ-011 SHALL have port host_to_agent  input  32  write data.
REQ-012 SHALL have port waitrequest  output  1  command presented this cycle not accepted.
REQ-013 SHALL have port agent_to_host  output  32  read data, valid only with readdatavalid.
REQ-014 SHALL have port readdatavalid  output  1  agent_to_host carries one read response.
REQ-015 SHALL have port protocol_error  output  1  sticky host protocol violation flag.

Function
REQ-016 SHALL index RAM with address[log2(DEPTH_WORDS)+1:2]; bits 1:0 and upper bits ignored (out-of-range addresses alias/wrap).
REQ-017 SHALL accept a command at a rising edge where (read|write)=1 and waitrequest=0.
REQ-018 SHALL implement a wait FSM: IDLE, HOLD; counter wait_cnt (3 bits).
REQ-019 In IDLE with command and WAIT_STATES=0: waitrequest=0 (subject to REQ-022); no state change.
REQ-020 In IDLE with command and WAIT_STATES>0: waitrequest=1; next HOLD, wait_cnt=1.
REQ-021 In HOLD: waitrequest=1 while wait_cnt<WAIT_STATES, wait_cnt increments; at wait_cnt=WAIT_STATES waitrequest=0 and on acceptance return to IDLE.
REQ-022 SHALL additionally hold waitrequest=1 for a read while registered outstanding count = MAX_PENDING, even if a response retires that cycle; writes are never blocked by this.
REQ-023 On write acceptance SHALL update only byte lanes with byteenable=1; byteenable=0000 writes nothing but is accepted.
REQ-024 On read acceptance at edge k SHALL sample the RAM word and assert readdatavalid for exactly one cycle, READ_LATENCY cycles later; responses strictly in acceptance order.
REQ-025 Write accepted at edge k followed by read of same word accepted at edge k+1 or later SHALL return the written data.
REQ-026 Outstanding counter SHALL +1 on read accept, -1 on readdatavalid, unchanged when both occur same cycle; never exceeds MAX_PENDING.
REQ-027 agent_to_host SHALL be 0 whenever readdatavalid=0.
REQ-028 If read and write both asserted: SHALL perform the write only, drop the read, set protocol_error.
REQ-029 If command deasserted or its address/type changed while in HOLD: SHALL return to IDLE without accepting, set protocol_error.
REQ-030 protocol_error SHALL stay 1 until reset.
REQ-031 waitrequest SHALL be 0 when neither read nor write is asserted.

Reset
REQ-032 While rst=0: waitrequest=0, readdatavalid=0, agent_to_host=0, protocol_error=0, FSM=IDLE, wait_cnt=0, outstanding=0, response pipeline cleared.
REQ-033 Reset mid-operation SHALL discard all in-flight reads; no readdatavalid after release for pre-reset requests.
REQ-034 RAM contents SHALL NOT be reset.

Verification
REQ-035 Defaults; write 0xDEADBEEF to 0x10, be=1111 -> waitrequest=1 one cycle, accepted second cycle; read 0x10 -> accepted after 1 wait cycle, readdatavalid 2 cycles later with 0xDEADBEEF.
REQ-036 Byte lanes: write 0x11223344 be=1111 then 0xAABBCCDD be=0101 to 0x20 -> read returns 0x11BB33DD.
REQ-037 WAIT_STATES=0, READ_LATENCY=4, MAX_PENDING=2; back-to-back reads of 0x0,0x4,0x8 -> third read stalled until first response retires; three responses in order, one per acceptance.
REQ-038 Aliasing: DEPTH_WORDS=1024, write 0x5A5A5A5A to 0x1004 -> read 0x0004 returns 0x5A5A5A5A; read 0x0006 same.
REQ-039 read=write=1 at 0x30 with data 0x0000FFFF -> write performed, no readdatavalid, protocol_error=1 until rst=0.
REQ-040 Two reads in flight, assert rst=0 one cycle -> readdatavalid=0 for 10 cycles after release, outstanding=0, next read completes normally.
